// File: rtl/multi_channel_pll.sv
// rtl/multi_channel_pll.sv - digital multi-channel PLL: reference phase tracking, lock FSM, phase-programmable clock outputs
// Optional reference watchdog: define PLL_REF_WATCHDOG_EN.
module multi_channel_pll #(
  parameter int NCH      = 4,
  parameter int DIV_LOG2 = 5,
  parameter int CNT_W    = 12
) (
  input  logic                    clk1280,
  input  logic                    reset,
  input  logic                    clk40Ref,
  input  logic                    startCalibration,
  input  logic [CNT_W-1:0]        calibrationTime,
  input  logic [CNT_W-1:0]        lockTime,
  input  logic [NCH*DIV_LOG2-1:0] clockDelay,
  input  logic [NCH*DIV_LOG2-1:0] pulseWidth,
  input  logic [NCH-1:0]          chEnable,
  output logic [NCH-1:0]          clkOut,
  output logic                    pllCalibrationDone,
  output logic                    locked,
  output logic                    instantLock,
  output logic [DIV_LOG2-1:0]     phaseCount,
  output logic [1:0]              pllState
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALIB   = 2'd1,
    LOCKING = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam logic [DIV_LOG2-1:0] ALIGN     = DIV_LOG2'(3);
  localparam logic [DIV_LOG2-1:0] PHASE_ONE = DIV_LOG2'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

  state_t              state;
  logic                refSync1;
  logic                refSync2;
  logic                refDelay;
  logic                refEdge;
  logic                inPhase;
  logic                startReg;
  logic                startRise;
  logic                wdExpired;
  logic [CNT_W-1:0]    edgeCount;
  logic [CNT_W-1:0]    edgeCountInc;
  logic [DIV_LOG2-1:0] riseAt  [NCH];
  logic [DIV_LOG2-1:0] widthAt [NCH];
  logic [DIV_LOG2-1:0] fallAt  [NCH];

  assign refEdge      = refSync2 & ~refDelay;
  assign inPhase      = (phaseCount + PHASE_ONE) == ALIGN;
  assign startRise    = startCalibration & ~startReg;
  assign edgeCountInc = (edgeCount == CNT_MAX) ? edgeCount : edgeCount + CNT_ONE;
  assign pllState     = state;
  assign locked       = (state == LOCKED);

  // Reference is sampled as data: two flops for metastability, a third to find the rising edge.
  always_ff @(posedge clk1280 or negedge reset) begin
    if (!reset) begin
      refSync1   <= 1'b0;
      refSync2   <= 1'b0;
      refDelay   <= 1'b0;
      startReg   <= 1'b0;
      phaseCount <= '0;
    end else begin
      refSync1   <= clk40Ref;
      refSync2   <= refSync1;
      refDelay   <= refSync2;
      startReg   <= startCalibration;
      phaseCount <= refEdge ? ALIGN : phaseCount + PHASE_ONE;
    end
  end

`ifdef PLL_REF_WATCHDOG_EN
  localparam int               WD_W     = DIV_LOG2 + 2;
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(2 ** (DIV_LOG2 + 1));
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);

  logic [WD_W-1:0] watchdog;

  assign wdExpired = (watchdog == WD_LIMIT);

  always_ff @(posedge clk1280 or negedge reset) begin
    if (!reset) begin
      watchdog <= '0;
    end else if (refEdge) begin
      watchdog <= '0;
    end else if (!wdExpired) begin
      watchdog <= watchdog + WD_ONE;
    end
  end
`else
  assign wdExpired = 1'b0;
`endif

  // A restart request wins over everything, including a reference edge in the same cycle.
  always_ff @(posedge clk1280 or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      edgeCount          <= '0;
      pllCalibrationDone <= 1'b0;
      instantLock        <= 1'b0;
    end else begin
      if (refEdge) instantLock <= inPhase;
      if (startRise) begin
        state              <= CALIB;
        edgeCount          <= '0;
        pllCalibrationDone <= 1'b0;
      end else if (wdExpired && state != IDLE) begin
        state              <= IDLE;
        edgeCount          <= '0;
        pllCalibrationDone <= 1'b0;
        instantLock        <= 1'b0;
      end else if (refEdge) begin
        case (state)
          CALIB: begin
            if (edgeCount == calibrationTime) begin
              state              <= LOCKING;
              edgeCount          <= '0;
              pllCalibrationDone <= 1'b1;
            end else begin
              edgeCount <= edgeCountInc;
            end
          end
          LOCKING: begin
            if (!inPhase) begin
              edgeCount <= '0;
            end else if (edgeCount == lockTime) begin
              state     <= LOCKED;
              edgeCount <= '0;
            end else begin
              edgeCount <= edgeCountInc;
            end
          end
          LOCKED: begin
            if (!inPhase) begin
              state     <= LOCKING;
              edgeCount <= '0;
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      riseAt[i]  = clockDelay[i*DIV_LOG2 +: DIV_LOG2];
      widthAt[i] = pulseWidth[i*DIV_LOG2 +: DIV_LOG2];
      fallAt[i]  = riseAt[i] + widthAt[i];
    end
  end

  // Outputs only toggle on phase matches, so reprogramming while locked can never glitch.
  always_ff @(posedge clk1280 or negedge reset) begin
    if (!reset) begin
      clkOut <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!chEnable[i] || state != LOCKED || widthAt[i] == '0) begin
          clkOut[i] <= 1'b0;
        end else if (phaseCount == riseAt[i]) begin
          clkOut[i] <= 1'b1;
        end else if (phaseCount == fallAt[i]) begin
          clkOut[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/multi_channel_pll.md
MULTI_CHANNEL_PLL -- requirements
Module: multi_channel_pll

Interface
REQ-001 Parameter NCH, default 4: number of output clock channels, range 1..8.
REQ-002 Parameter DIV_LOG2, default 5: log2 of clk1280/clk40Ref ratio; phase counter width.
REQ-003 Parameter CNT_W, default 12: width of calibrationTime, lockTime and the internal edge counter.
REQ-004 Ports: clk1280 in 1, sole clock; all logic on posedge.
REQ-005 Ports: reset in 1, asynchronous, active-low.
REQ-006 Ports: clk40Ref in 1, reference clock, asynchronous to clk1280, sampled as data.
REQ-007 Ports: startCalibration in 1, level; rising edge starts calibration.
REQ-008 Ports: calibrationTime in CNT_W; lockTime in CNT_W; counts of reference edges.
REQ-009 Ports: clockDelay in NCH*DIV_LOG2, per-channel rising phase; pulseWidth in NCH*DIV_LOG2, per-channel high phases; chEnable in NCH.
REQ-010 Ports: clkOut out NCH; pllCalibrationDone out 1; locked out 1; instantLock out 1; phaseCount out DIV_LOG2; pllState out 2.

Function
REQ-011 clk40Ref SHALL pass a 2-FF synchronizer, then an edge register; refEdge = sync high and edge register low, one cycle wide.
REQ-012 phaseCount SHALL increment modulo 2^DIV_LOG2 each cycle; on refEdge it SHALL load ALIGN = 3.
REQ-013 A refEdge SHALL be in-phase iff (phaseCount+1) mod 2^DIV_LOG2 == ALIGN in that cycle.
REQ-014 instantLock SHALL be a register updated on every refEdge with the in-phase result, holding otherwise.
REQ-015 startCalibration SHALL be registered; startRise = current high and previous low.
REQ-016 pllState encoding: IDLE=0, CALIB=1, LOCKING=2, LOCKED=3.
REQ-017 IDLE: startRise -> CALIB, edge counter cleared.
REQ-018 CALIB: counter increments per refEdge; refEdge with counter == calibrationTime -> LOCKING, counter cleared, pllCalibrationDone set (calibrationTime=N needs N+1 edges).
REQ-019 LOCKING: in-phase refEdge increments counter; out-of-phase refEdge clears it; in-phase refEdge with counter == lockTime -> LOCKED.
REQ-020 LOCKED: out-of-phase refEdge -> LOCKING with counter cleared; pllCalibrationDone stays set.
REQ-021 startRise in CALIB/LOCKING/LOCKED SHALL restart CALIB with counter cleared and pllCalibrationDone cleared; startRise has priority over a simultaneous refEdge.
REQ-022 Counter SHALL saturate at 2^CNT_W-1, never wrap.
REQ-023 locked = (pllState == LOCKED), combinational from the state register.
REQ-024 Per channel i: rise = clockDelay[i], fall = (rise + pulseWidth[i]) mod 2^DIV_LOG2; clkOut[i] registered: set when phaseCount == rise, cleared when phaseCount == fall, else hold.
REQ-025 pulseWidth[i] == 0: clkOut[i] SHALL be held 0.
REQ-026 clkOut[i] SHALL be forced 0 (registered) when chEnable[i] is 0 or locked is 0.
REQ-027 Changing clockDelay/pulseWidth while locked SHALL take effect on the next phaseCount match; no glitch shorter than one clk1280 period.

Reset
REQ-028 reset low SHALL asynchronously clear: synchronizer and edge registers, phaseCount=0, counter=0, pllState=IDLE, pllCalibrationDone=0, instantLock=0, clkOut=0, startCalibration register=0, watchdog=0.
REQ-029 Reset asserted mid-calibration or mid-lock SHALL return to IDLE; recovery requires a fresh startRise after deassertion.

Configuration
REQ-030 Macro PLL_REF_WATCHDOG_EN defined: a watchdog counts cycles since last refEdge, cleared on refEdge; reaching 2*2^DIV_LOG2 in any non-IDLE state -> IDLE, pllCalibrationDone cleared, instantLock cleared.
REQ-031 Macro undefined: no watchdog logic; a missing reference leaves the state unchanged.

Verification
REQ-032 clk40Ref at exactly 1/32 of clk1280, calibrationTime=4, lockTime=8, startCalibration pulse -> CALIB after 5 edges LOCKING, after 9 more in-phase edges locked=1, instantLock=1.
REQ-033 Locked; clockDelay[0]=0, pulseWidth[0]=16; clockDelay[1]=8, pulseWidth[1]=4 -> clkOut[0] 50% duty, clkOut[1] high 4 cycles starting 8 cycles after clkOut[0] rise.
REQ-034 Locked; shift one reference edge by 2 clk1280 cycles -> instantLock=0, pllState=LOCKING, counter cleared, relock after 9 in-phase edges.
REQ-035 pulseWidth[2]=0 or chEnable[3]=0 -> clkOut[2], clkOut[3] constant 0; startRise during LOCKING -> CALIB, pllCalibrationDone=0.
REQ-036 PLL_REF_WATCHDOG_EN defined, locked, stop clk40Ref -> IDLE after 64 cycles without an edge; undefined -> remains LOCKED.
REQ-037 Assert reset during LOCKING -> all outputs zero immediately, pllState=IDLE; reference alone does not restart calibration.
